// File: rtl/leglite_pkg.sv
// Shared constants for the LEGLite data-side memory map.
// I/O registers sit in the top page; anything with daddr[15]==0 is RAM.
package leglite_pkg;

    localparam logic [15:0] ADDR_LED   = 16'hFFF0;
    localparam logic [15:0] ADDR_SW    = 16'hFFF1;
    localparam logic [15:0] ADDR_TIMER = 16'hFFF2;
    localparam logic [15:0] ADDR_TCTRL = 16'hFFF3;
    localparam logic [15:0] ADDR_FLAG  = 16'hFFF4;

    localparam int TCTRL_EN  = 0;
    localparam int TCTRL_CLR = 1;

endpackage

// File: rtl/leglite_data_mem_if.sv
// CPU data bus between the single-cycle datapath and the data memory responder.
// No handshake: a read or write is issued and completes in the same cycle
// (dread returns ddata combinationally, dwrite commits on the next rising edge).
interface leglite_data_mem_if;

    logic [15:0] daddr;
    logic        dread;
    logic        dwrite;
    logic [15:0] dwdata;
    logic [15:0] ddata;

    modport master (output daddr, output dread, output dwrite, output dwdata, input ddata);
    modport slave  (input daddr, input dread, input dwrite, input dwdata, output ddata);

endinterface

// File: rtl/leglite_io_timer.sv
// Free-running 16-bit timer with enable register and a self-clearing clear strobe.
module leglite_io_timer
    import leglite_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_tctrl,
    input  logic [1:0]  wdata,
    output logic [15:0] count,
    output logic        enable
);

    logic [15:0] count_q, count_d;
    logic        enable_q, enable_d;

    // Increment uses the enable held before this edge; a clear overrides it.
    always_comb begin
        enable_d = enable_q;
        count_d  = count_q;
        if (enable_q) begin
            count_d = count_q + 16'd1;
        end
        if (wr_tctrl) begin
            enable_d = wdata[TCTRL_EN];
            if (wdata[TCTRL_CLR]) begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            enable_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            enable_q <= enable_d;
        end
    end

    assign count  = count_q;
    assign enable = enable_q;

endmodule

// File: rtl/leglite_data_mem.sv
// Data memory responder: word RAM (mirrored in the lower half of the address
// space) plus an I/O page with LEDs, synchronized switches, timer and change flag.
module leglite_data_mem
    import leglite_pkg::*;
#(
    parameter int DEPTH_LOG2 = 7
) (
    input  logic               clock,
    input  logic               reset,
    leglite_data_mem_if.slave  bus,
    input  logic [15:0]        sw,
    output logic [15:0]        led
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0] ram_q [DEPTH];
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic        ram_we;

    logic [15:0] led_q, led_d;
    logic [15:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic        flag_q, flag_d;

    logic        wr_led, wr_tctrl, wr_flag;
    logic [15:0] timer_count;
    logic        timer_enable;
    logic [15:0] rd_word;

    assign ram_idx  = bus.daddr[DEPTH_LOG2-1:0];
    // RAM has no reset; keep it frozen while reset is held.
    assign ram_we   = bus.dwrite && !bus.daddr[15] && reset;
    assign wr_led   = bus.dwrite && (bus.daddr == ADDR_LED);
    assign wr_tctrl = bus.dwrite && (bus.daddr == ADDR_TCTRL);
    assign wr_flag  = bus.dwrite && (bus.daddr == ADDR_FLAG);

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_q[ram_idx] <= bus.dwdata;
        end
    end

    leglite_io_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .wr_tctrl (wr_tctrl),
        .wdata    (bus.dwdata[1:0]),
        .count    (timer_count),
        .enable   (timer_enable)
    );

    // A switch change seen this edge beats a software clear of the flag.
    always_comb begin
        led_d  = wr_led ? bus.dwdata : led_q;
        s1_d   = sw;
        s2_d   = s1_q;
        s3_d   = s2_q;
        flag_d = flag_q;
        if (s2_q != s3_q) begin
            flag_d = 1'b1;
        end else if (wr_flag) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            flag_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            flag_q <= flag_d;
        end
    end

    always_comb begin
        rd_word = '0;
        if (!bus.daddr[15]) begin
            rd_word = ram_q[ram_idx];
        end else begin
            case (bus.daddr)
                ADDR_LED:   rd_word = led_q;
                ADDR_SW:    rd_word = s2_q;
                ADDR_TIMER: rd_word = timer_count;
                ADDR_TCTRL: rd_word = {15'b0, timer_enable};
                ADDR_FLAG:  rd_word = {15'b0, flag_q};
                default:    rd_word = '0;
            endcase
        end
    end

    assign bus.ddata = bus.dread ? rd_word : 16'h0000;
    assign led       = led_q;

endmodule

// File: tb/tb_leglite_data_mem.sv
// Directed plus randomized bench for leglite_data_mem against a behavioural memory-map model.
module tb_leglite_data_mem;
    import leglite_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic [15:0] led;
    logic [15:0] seen;

    int checks   = 0;
    int failures = 0;

    leglite_data_mem_if bus ();

    leglite_data_mem #(.DEPTH_LOG2(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .sw    (sw),
        .led   (led)
    );

    always #5 clock = ~clock;

    // Reference model: memory-map contents and the switch value sampled at past edges.
    logic [15:0] m_ram [128];
    bit          m_known [128];
    logic [15:0] m_led;
    logic [15:0] m_timer;
    bit          m_en;
    bit          m_flag;
    logic [15:0] m_sw_hist [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led   = 16'h0;
        m_timer = 16'h0;
        m_en    = 1'b0;
        m_flag  = 1'b0;
        m_sw_hist = {16'h0, 16'h0, 16'h0};
    endtask

    // m_sw_hist[1] is the switch value sampled two edges ago, i.e. what software sees.
    function automatic logic [15:0] model_read(input logic [15:0] a, output bit known);
        logic [15:0] v;
        known = 1'b1;
        v = 16'h0;
        if (!a[15]) begin
            known = m_known[a[6:0]];
            v = m_ram[a[6:0]];
        end else if (a == ADDR_LED)   v = m_led;
        else if (a == ADDR_SW)        v = m_sw_hist[1];
        else if (a == ADDR_TIMER)     v = m_timer;
        else if (a == ADDR_TCTRL)     v = {15'b0, m_en};
        else if (a == ADDR_FLAG)      v = {15'b0, m_flag};
        return v;
    endfunction

    task automatic model_edge(input logic [15:0] a, input bit wr, input logic [15:0] wd);
        bit visible_changed;
        visible_changed = (m_sw_hist[1] != m_sw_hist[2]);
        if (wr && !a[15]) begin
            m_ram[a[6:0]]   = wd;
            m_known[a[6:0]] = 1'b1;
        end
        if (wr && a == ADDR_LED) m_led = wd;
        if (wr && a == ADDR_TCTRL) begin
            if (wd[1])     m_timer = 16'h0;
            else if (m_en) m_timer = m_timer + 16'd1;
            m_en = wd[0];
        end else if (m_en) begin
            m_timer = m_timer + 16'd1;
        end
        if (visible_changed)              m_flag = 1'b1;
        else if (wr && a == ADDR_FLAG)    m_flag = 1'b0;
        m_sw_hist.push_front(sw);
        void'(m_sw_hist.pop_back());
    endtask

    // Called at a falling edge; drives one bus cycle, checks mid-phase, advances past the rising edge.
    task automatic bus_cycle(input logic [15:0] a, input bit rd, input bit wr,
                             input logic [15:0] wd, output logic [15:0] obs);
        logic [15:0] exp;
        bit          known;
        bus.daddr  = a;
        bus.dread  = rd;
        bus.dwrite = wr;
        bus.dwdata = wd;
        #1;
        exp = model_read(a, known);
        if (!rd) begin
            exp   = 16'h0;
            known = 1'b1;
        end
        obs = bus.ddata;
        if (known) check("ddata", bus.ddata, exp);
        check("led", led, m_led);
        @(posedge clock);
        model_edge(a, wr, wd);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        logic [15:0] dummy;
        for (int i = 0; i < n; i++) bus_cycle(16'h0000, 1'b0, 1'b0, 16'h0, dummy);
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases it at the next falling edge.
    task automatic apply_reset();
        bus.dwrite = 1'b0;
        bus.dread  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_led_async", led, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] wd;
        bit          rd, wr;

        reset      = 1'b0;
        sw         = 16'h0;
        bus.daddr  = 16'h0;
        bus.dread  = 1'b0;
        bus.dwrite = 1'b0;
        bus.dwdata = 16'h0;
        for (int i = 0; i < 128; i++) m_known[i] = 1'b0;
        model_reset();

        // Reset state, observed combinationally while reset is held.
        #2;
        bus.dread = 1'b1;
        bus.daddr = ADDR_TIMER; #1; check("rst_timer", bus.ddata, 16'h0000);
        bus.daddr = ADDR_TCTRL; #1; check("rst_tctrl", bus.ddata, 16'h0000);
        bus.daddr = ADDR_FLAG;  #1; check("rst_flag",  bus.ddata, 16'h0000);
        bus.daddr = ADDR_SW;    #1; check("rst_sw",    bus.ddata, 16'h0000);
        check("rst_led", led, 16'h0000);
        bus.dread = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Timer: enable, count 10, clear while enabled, keep counting.
        bus_cycle(ADDR_TCTRL, 1'b0, 1'b1, 16'h0001, seen);
        idle(10);
        bus_cycle(ADDR_TIMER, 1'b1, 1'b0, 16'h0, seen); check("timer_10", seen, 16'd10);
        bus_cycle(ADDR_TCTRL, 1'b0, 1'b1, 16'h0003, seen);
        bus_cycle(ADDR_TIMER, 1'b1, 1'b0, 16'h0, seen); check("timer_clr", seen, 16'd0);
        bus_cycle(ADDR_TIMER, 1'b1, 1'b0, 16'h0, seen); check("timer_cont", seen, 16'd1);

        // RAM write/readback and mirroring.
        bus_cycle(16'h0005, 1'b0, 1'b1, 16'h1234, seen);
        bus_cycle(16'h0005, 1'b1, 1'b0, 16'h0, seen); check("ram_rd", seen, 16'h1234);
        bus_cycle(16'h0085, 1'b1, 1'b0, 16'h0, seen); check("ram_mirror", seen, 16'h1234);
        bus_cycle(16'h0005, 1'b0, 1'b0, 16'h0, seen); check("ram_noread", seen, 16'h0000);

        // LED register, then asynchronous reset mid-cycle.
        bus_cycle(ADDR_LED, 1'b0, 1'b1, 16'hA5A5, seen);
        check("led_after_wr", led, 16'hA5A5);
        bus_cycle(ADDR_LED, 1'b1, 1'b0, 16'h0, seen); check("led_rd", seen, 16'hA5A5);
        apply_reset();

        // Switch synchronizer and sticky flag.
        sw = 16'h00FF;
        idle(2);
        bus_cycle(ADDR_SW,   1'b1, 1'b0, 16'h0, seen); check("sw_sync", seen, 16'h00FF);
        bus_cycle(ADDR_FLAG, 1'b1, 1'b0, 16'h0, seen); check("flag_set", seen, 16'h0001);
        bus_cycle(ADDR_FLAG, 1'b0, 1'b1, 16'h0, seen);
        bus_cycle(ADDR_FLAG, 1'b1, 1'b0, 16'h0, seen); check("flag_clr", seen, 16'h0000);
        sw = 16'h0F0F;
        idle(2);
        bus_cycle(ADDR_FLAG, 1'b0, 1'b1, 16'h0, seen);
        bus_cycle(ADDR_FLAG, 1'b1, 1'b0, 16'h0, seen); check("flag_set_wins", seen, 16'h0001);

        // Timer wrap after a full 2**16 count.
        bus_cycle(ADDR_TCTRL, 1'b0, 1'b1, 16'h0003, seen);
        idle(65536);
        bus_cycle(ADDR_TIMER, 1'b1, 1'b0, 16'h0, seen); check("timer_wrap", seen, 16'd0);

        // Unmapped page and read/write collision.
        bus_cycle(16'hFFF8, 1'b1, 1'b0, 16'h0, seen); check("unmapped_rd", seen, 16'h0000);
        bus_cycle(16'hFFF8, 1'b0, 1'b1, 16'hFFFF, seen);
        check("unmapped_led", led, 16'h0000);
        bus_cycle(ADDR_TCTRL, 1'b1, 1'b0, 16'h0, seen); check("unmapped_tctrl", seen, 16'h0001);
        bus_cycle(ADDR_FLAG,  1'b1, 1'b0, 16'h0, seen); check("unmapped_flag", seen, 16'h0001);
        bus_cycle(16'h0003, 1'b0, 1'b1, 16'h0001, seen);
        bus_cycle(16'h0003, 1'b1, 1'b1, 16'h0002, seen); check("collide_old", seen, 16'h0001);
        bus_cycle(16'h0003, 1'b1, 1'b0, 16'h0, seen); check("collide_new", seen, 16'h0002);

        // Randomized traffic across RAM, I/O page and unmapped space.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 16'($urandom_range(0, 16'h7FFF));
                5, 6, 7, 8:    a = 16'hFFF0 + 16'($urandom_range(0, 4));
                default:       a = 16'hFFF5 + 16'($urandom_range(0, 10));
            endcase
            rd = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 2) == 0);
            wd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
            bus_cycle(a, rd, wr, wd, seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
